rr_req_arbiter: RTL and testbench

- Upstream stage for the 8:3 encoder.
- Captures 8 asynchronous-in-time request pulses into sticky pending bits and picks one with a rotating (round-robin) priority.
- Presents the winner as a registered one-hot vector plus a valid strobe. These drive the encoder's 8-bit one-hot input and its enable directly.
- Holds the grant until the consumer acknowledges it.

---
 rtl/rr_req_arbiter.sv | 106 ++++++++++
 tb/tb_rr_req_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// Round-robin request arbiter: sticky pending capture, registered one-hot grant and valid strobe held until ack.
// Optional RR_ARB_FIXED_PRIO_EN: scan always starts at index 0 (lowest pending bit wins), ptr stays 0.
module rr_req_arbiter #(
   parameter int N  = 8,
   parameter int PW = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] req,
   input  logic         ack,
   output logic [N-1:0] grant,
   output logic         en,
   output logic [N-1:0] pending
);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t        state, state_next;
   logic [PW-1:0] ptr, ptr_next;
   logic [PW-1:0] idx, idx_next;
   logic [PW-1:0] start, cand, sel;
   logic          found;
   logic [N-1:0]  clr, pending_next, grant_next;
   logic          en_next;

`ifdef RR_ARB_FIXED_PRIO_EN
   assign start = '0;
`else
   assign start = ptr;
`endif

   // N is a power of two, so PW-bit addition wraps the scan modulo N for free.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      cand  = '0;
      for (int unsigned k = 0; k < N; k++) begin
         cand = start + PW'(k);
         if (!found && pending[cand]) begin
            found = 1'b1;
            sel   = cand;
         end
      end
   end

   always_comb begin
      clr          = (en && ack) ? grant : '0;
      // A request arriving with its own clear survives.
      pending_next = (pending & ~clr) | req;
      state_next   = state;
      grant_next   = grant;
      en_next      = en;
      ptr_next     = ptr;
      idx_next     = idx;
      case (state)
         IDLE: begin
            if (found) begin
               grant_next = N'(1) << sel;
               en_next    = 1'b1;
               idx_next   = sel;
               state_next = GRANT;
            end else begin
               grant_next = '0;
               en_next    = 1'b0;
            end
         end
         GRANT: begin
            if (ack) begin
               grant_next = '0;
               en_next    = 1'b0;
               state_next = IDLE;
`ifndef RR_ARB_FIXED_PRIO_EN
               ptr_next   = idx + PW'(1);
`endif
            end
         end
         default: begin
            grant_next = '0;
            en_next    = 1'b0;
            state_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         ptr     <= '0;
         idx     <= '0;
         grant   <= '0;
         en      <= 1'b0;
         pending <= '0;
      end else begin
         state   <= state_next;
         ptr     <= ptr_next;
         idx     <= idx_next;
         grant   <= grant_next;
         en      <= en_next;
         pending <= pending_next;
      end
   end

endmodule

// File: tb/tb_rr_req_arbiter.sv
// Directed self-checking bench for rr_req_arbiter; expectations depend on RR_ARB_FIXED_PRIO_EN.
module tb_rr_req_arbiter;

   logic       clk;
   logic       rst_n;
   logic [7:0] req;
   logic       ack;
   logic [7:0] grant;
   logic       en;
   logic [7:0] pending;

   int total;
   int bad;

   rr_req_arbiter #(.N(8)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .ack     (ack),
      .grant   (grant),
      .en      (en),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = '0;
      ack   = 1'b0;
      rst_n = 1'b0;
      repeat (2) tick();
      rst_n = 1'b1;
      tick();
   endtask

   // Waits (bounded) for en and returns the grant seen; caller does the comparison.
   task automatic wait_grant(output logic [7:0] g, output bit timed_out);
      timed_out = 1'b1;
      g = '0;
      for (int i = 0; i < 20; i++) begin
         if (en === 1'b1) begin
            g = grant;
            timed_out = 1'b0;
            break;
         end
         tick();
      end
   endtask

   task automatic do_ack();
      ack = 1'b1;
      tick();
      ack = 1'b0;
   endtask

   task automatic test_reset();
      req   = '0;
      ack   = 1'b0;
      rst_n = 1'b0;
      #2;
      for (int c = 0; c < 2; c++) begin
         total++;
         if ({grant, en, pending} !== 17'h0) begin
            bad++;
            $display("FAIL reset_hold c=%0d got grant=%b en=%b pending=%b want 0", c, grant, en, pending);
         end
         tick();
      end
      rst_n = 1'b1;
      ack = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if ({grant, en, pending} !== 17'h0) begin
            bad++;
            $display("FAIL idle_after_reset c=%0d got grant=%b en=%b pending=%b want 0", c, grant, en, pending);
         end
      end
      ack = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      req = 8'b0000_0100;
      tick();
      req = '0;
      total++;
      if (pending !== 8'b0000_0100 || en !== 1'b0) begin
         bad++;
         $display("FAIL single_pend got pending=%b en=%b want 00000100 0", pending, en);
      end
      tick();
      total++;
      if (grant !== 8'b0000_0100 || en !== 1'b1) begin
         bad++;
         $display("FAIL single_latency got grant=%b en=%b want 00000100 1", grant, en);
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         total++;
         if (grant !== 8'b0000_0100 || en !== 1'b1 || pending !== 8'b0000_0100) begin
            bad++;
            $display("FAIL single_hold c=%0d got grant=%b en=%b pending=%b", c, grant, en, pending);
         end
      end
      do_ack();
      total++;
      if ({grant, en, pending} !== 17'h0) begin
         bad++;
         $display("FAIL single_ack got grant=%b en=%b pending=%b want 0", grant, en, pending);
      end
      tick();
      total++;
      if (en !== 1'b0) begin
         bad++;
         $display("FAIL single_stay_idle got en=%b want 0", en);
      end
   endtask

   task automatic test_round_robin();
      logic [7:0] g;
      bit         to;
      logic [7:0] seq_a [2] = '{8'h01, 8'h80};
      logic [7:0] seq_b [2] = '{8'h01, 8'h02};
      logic [7:0] seq_c [8] = '{8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
      do_reset();
      req = 8'h81;
      tick();
      req = '0;
      for (int i = 0; i < 2; i++) begin
         wait_grant(g, to);
         total++;
         if (to || g !== seq_a[i]) begin
            bad++;
            $display("FAIL rr_wrap i=%0d got grant=%b timeout=%0d want %b", i, g, to, seq_a[i]);
         end
         do_ack();
         total++;
         if (en !== 1'b0 || grant !== 8'h00) begin
            bad++;
            $display("FAIL rr_bubble i=%0d got en=%b grant=%b want 0", i, en, grant);
         end
      end
      req = 8'h03;
      tick();
      req = '0;
      for (int i = 0; i < 2; i++) begin
         wait_grant(g, to);
         total++;
         if (to || g !== seq_b[i]) begin
            bad++;
            $display("FAIL rr_after_wrap i=%0d got grant=%b timeout=%0d want %b", i, g, to, seq_b[i]);
         end
         do_ack();
      end
      req = 8'hFF;
      tick();
      req = '0;
      for (int i = 0; i < 8; i++) begin
         wait_grant(g, to);
         total++;
         if (to || g !== seq_c[i]) begin
            bad++;
            $display("FAIL rr_all i=%0d got grant=%b timeout=%0d want %b", i, g, to, seq_c[i]);
         end
         do_ack();
      end
      total++;
      if (pending !== 8'h00) begin
         bad++;
         $display("FAIL rr_drained got pending=%b want 00000000", pending);
      end
   endtask

   task automatic test_collision();
      logic [7:0] g;
      bit         to;
      do_reset();
      req = 8'h10;
      tick();
      req = '0;
      wait_grant(g, to);
      total++;
      if (to || g !== 8'h10) begin
         bad++;
         $display("FAIL coll_first got grant=%b timeout=%0d want 00010000", g, to);
      end
      req = 8'h40;
      tick();
      req = '0;
      total++;
      if (grant !== 8'h10 || en !== 1'b1 || pending !== 8'h50) begin
         bad++;
         $display("FAIL coll_accum got grant=%b en=%b pending=%b want 00010000 1 01010000", grant, en, pending);
      end
      ack = 1'b1;
      req = 8'h10;
      tick();
      ack = 1'b0;
      req = '0;
      total++;
      if (pending !== 8'h50 || en !== 1'b0) begin
         bad++;
         $display("FAIL coll_set_wins got pending=%b en=%b want 01010000 0", pending, en);
      end
      wait_grant(g, to);
      total++;
      if (to || g !== 8'h40) begin
         bad++;
         $display("FAIL coll_next got grant=%b timeout=%0d want 01000000", g, to);
      end
      do_ack();
      wait_grant(g, to);
      total++;
      if (to || g !== 8'h10) begin
         bad++;
         $display("FAIL coll_regrant got grant=%b timeout=%0d want 00010000", g, to);
      end
      do_ack();
      total++;
      if (pending !== 8'h00) begin
         bad++;
         $display("FAIL coll_drained got pending=%b want 00000000", pending);
      end
   endtask

   task automatic test_reset_mid_grant();
      do_reset();
      req = 8'h28;
      tick();
      req = '0;
      tick();
      total++;
      if (grant !== 8'h08 || en !== 1'b1 || pending !== 8'h28) begin
         bad++;
         $display("FAIL mid_setup got grant=%b en=%b pending=%b want 00001000 1 00101000", grant, en, pending);
      end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if ({grant, en, pending} !== 17'h0) begin
         bad++;
         $display("FAIL mid_async_reset got grant=%b en=%b pending=%b want 0", grant, en, pending);
      end
      #3;
      rst_n = 1'b1;
      tick();
      total++;
      if ({grant, en, pending} !== 17'h0) begin
         bad++;
         $display("FAIL mid_after_release got grant=%b en=%b pending=%b want 0", grant, en, pending);
      end
   endtask

   task automatic test_fixed_prio();
      logic [7:0] g;
      bit         to;
      logic [7:0] seq [3] = '{8'h04, 8'h20, 8'h80};
      logic [7:0] seq2 [4] = '{8'h01, 8'h04, 8'h20, 8'h80};
      do_reset();
      req = 8'hA4;
      tick();
      req = '0;
      for (int i = 0; i < 3; i++) begin
         wait_grant(g, to);
         total++;
         if (to || g !== seq[i]) begin
            bad++;
            $display("FAIL fixed_order i=%0d got grant=%b timeout=%0d want %b", i, g, to, seq[i]);
         end
         do_ack();
      end
      req = 8'hA4;
      tick();
      req = '0;
      wait_grant(g, to);
      total++;
      if (to || g !== 8'h04) begin
         bad++;
         $display("FAIL fixed_repeat got grant=%b timeout=%0d want 00000100", g, to);
      end
      ack = 1'b1;
      req = 8'h05;
      tick();
      ack = 1'b0;
      req = '0;
      for (int i = 0; i < 4; i++) begin
         wait_grant(g, to);
         total++;
         if (to || g !== seq2[i]) begin
            bad++;
            $display("FAIL fixed_low_wins i=%0d got grant=%b timeout=%0d want %b", i, g, to, seq2[i]);
         end
         do_ack();
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      req   = '0;
      ack   = 1'b0;
      rst_n = 1'b0;
      test_reset();
      test_single();
`ifdef RR_ARB_FIXED_PRIO_EN
      test_fixed_prio();
`else
      test_round_robin();
      test_collision();
`endif
      test_reset_mid_grant();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
